// File: rtl/axis_motion_controller.sv
// N-axis step/dir motion controller: shared step-rate prescaler, per-axis step
// engines with signed position, two-phase homing with per-axis step budgets.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | jog active, waiting for home_req
// HOME_A | axes 0..N-2 step toward their endstops together
// HOME_B | last axis (tool/Z) steps toward its endstop
// FAULT  | homing step budget exhausted; no motion until home_req
module axis_motion_controller #(
    parameter int                N_AXES         = 3,
    parameter int                STEP_DIV       = 50000,
    parameter int                PULSE_W        = 100,
    parameter int                POS_W          = 16,
    parameter logic [N_AXES-1:0] HOME_DIR       = '0,
    parameter int                HOME_MAX_STEPS = 4000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    home_req,
    input  logic [N_AXES-1:0]       jog_pos,
    input  logic [N_AXES-1:0]       jog_neg,
    input  logic [N_AXES-1:0]       limit,
    output logic [N_AXES-1:0]       step,
    output logic [N_AXES-1:0]       dir,
    output logic [N_AXES*POS_W-1:0] position,
    output logic                    homed,
    output logic                    busy,
    output logic                    fault
);

    localparam int PRE_W = $clog2(STEP_DIV);
    localparam int PW_W  = $clog2(PULSE_W + 1);
    localparam int BUD_W = $clog2(HOME_MAX_STEPS + 1);
    localparam int LAST  = N_AXES - 1;

    typedef enum logic [1:0] {IDLE, HOME_A, HOME_B, FAULT} state_t;

    state_t            state, state_nx;
    logic [PRE_W-1:0]  presc;
    logic              tick;
    logic [N_AXES-1:0] req, req_dir, zero_pos;
    logic              start_home, home_done, all_lim, timeout;
    logic              homed_q;
    logic [PW_W-1:0]   pulse_cnt [N_AXES];
    logic [BUD_W-1:0]  budget    [N_AXES];
    logic [POS_W-1:0]  pos_q     [N_AXES];

    assign tick  = (presc == PRE_W'(STEP_DIV - 1));
    assign busy  = (state == HOME_A) || (state == HOME_B);
    assign fault = (state == FAULT);
    assign homed = homed_q;

    always_comb begin
        position = '0;
        for (int i = 0; i < N_AXES; i++) position[i*POS_W +: POS_W] = pos_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            state   <= IDLE;
            homed_q <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            state <= state_nx;
            if (start_home)     homed_q <= 1'b0;
            else if (home_done) homed_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        req        = '0;
        req_dir    = '0;
        zero_pos   = '0;
        start_home = 1'b0;
        home_done  = 1'b0;
        all_lim    = 1'b1;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                for (int i = 0; i < N_AXES; i++) begin
                    if (jog_pos[i] && !jog_neg[i]) begin
                        req[i]     = 1'b1;
                        req_dir[i] = ~HOME_DIR[i];
                    end else if (jog_neg[i] && !jog_pos[i] && !limit[i]) begin
                        req[i]     = 1'b1;
                        req_dir[i] = HOME_DIR[i];
                    end
                end
                if (home_req) begin
                    start_home = 1'b1;
                    state_nx   = HOME_A;
                end
            end
            HOME_A: begin
                for (int i = 0; i < LAST; i++) begin
                    req_dir[i] = HOME_DIR[i];
                    if (limit[i]) begin
                        zero_pos[i] = 1'b1;
                    end else begin
                        all_lim = 1'b0;
                        if (budget[i] == '0) timeout = 1'b1;
                        else                 req[i]  = 1'b1;
                    end
                end
                if (all_lim)      state_nx = HOME_B;
                else if (timeout) state_nx = FAULT;
            end
            HOME_B: begin
                req_dir[LAST] = HOME_DIR[LAST];
                if (limit[LAST]) begin
                    zero_pos[LAST] = 1'b1;
                    home_done      = 1'b1;
                    state_nx       = IDLE;
                end else if (budget[LAST] == '0) begin
                    state_nx = FAULT;
                end else begin
                    req[LAST] = 1'b1;
                end
            end
            FAULT: begin
                if (home_req) begin
                    start_home = 1'b1;
                    state_nx   = HOME_A;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A started pulse always runs out its width; only the step start is gated by req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
            dir  <= '0;
            for (int i = 0; i < N_AXES; i++) begin
                pulse_cnt[i] <= '0;
                budget[i]    <= '0;
                pos_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < N_AXES; i++) begin
                if (step[i]) begin
                    if (pulse_cnt[i] == '0) step[i]      <= 1'b0;
                    else                    pulse_cnt[i] <= pulse_cnt[i] - 1'b1;
                end
                if (tick && req[i]) begin
                    step[i]      <= 1'b1;
                    pulse_cnt[i] <= PW_W'(PULSE_W - 1);
                    dir[i]       <= req_dir[i];
                    pos_q[i]     <= (req_dir[i] != HOME_DIR[i]) ? pos_q[i] + 1'b1
                                                                : pos_q[i] - 1'b1;
                end
                if (zero_pos[i]) pos_q[i] <= '0;
                if (start_home)                   budget[i] <= BUD_W'(HOME_MAX_STEPS);
                else if (tick && req[i] && busy)  budget[i] <= budget[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_motion_controller.sv
// Scoreboard bench: stimulus pushes expected step events per axis; a monitor
// pops and compares on every step rising edge and checks pulse widths/gaps.
module tb_axis_motion_controller;

    localparam int N  = 3;
    localparam int SD = 10;
    localparam int PW = 3;
    localparam int PB = 8;

    typedef struct {
        logic       d;
        logic [7:0] p;
        int         gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, home_req;
    logic [N-1:0]  jog_pos, jog_neg, limit;
    logic [N-1:0]  step, dir;
    logic [N*PB-1:0] position;
    logic          homed, busy, fault;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   rise_cnt [N];
    int   last_rise[N];
    int   width    [N];
    logic prev     [N];
    logic [7:0] model_pos [N];
    exp_t q0[$], q1[$], q2[$];
    exp_t m_e;
    bit   m_got;

    axis_motion_controller #(
        .N_AXES(N), .STEP_DIV(SD), .PULSE_W(PW), .POS_W(PB),
        .HOME_DIR(3'b000), .HOME_MAX_STEPS(20)
    ) dut (
        .clk(clk), .rst(rst), .home_req(home_req),
        .jog_pos(jog_pos), .jog_neg(jog_neg), .limit(limit),
        .step(step), .dir(dir), .position(position),
        .homed(homed), .busy(busy), .fault(fault)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic d, input logic [7:0] p, input int gap);
        exp_t e;
        e.d = d; e.p = p; e.gap = gap;
        case (a)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic push_moves(input int a, input int n, input logic d);
        for (int k = 0; k < n; k++) begin
            model_pos[a] = d ? model_pos[a] + 8'd1 : model_pos[a] - 8'd1;
            push(a, d, model_pos[a], (k == 0) ? 0 : SD);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin @(negedge clk); #1; end
    endtask

    task automatic wait_rises(input int a, input int target, input int budget);
        int c = 0;
        while (rise_cnt[a] < target && c < budget) begin @(negedge clk); #1; c++; end
        if (rise_cnt[a] < target) begin
            n_checks++; n_err++;
            $display("FAIL wait_axis%0d: got %0d steps expected %0d", a, rise_cnt[a], target);
        end
    endtask

    task automatic pulse_home();
        home_req = 1'b1;
        @(negedge clk); #1;
        home_req = 1'b0;
    endtask

    // Monitor: reacts to whatever the DUT emits, independent of the stimulus thread.
    initial begin
        for (int i = 0; i < N; i++) begin
            prev[i] = 1'b0; width[i] = 0; rise_cnt[i] = 0; last_rise[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    prev[i]  = 1'b0;
                    width[i] = 0;
                end else begin
                    if (step[i] && !prev[i]) begin
                        m_got = 1'b0;
                        case (i)
                            0: if (q0.size() > 0) begin m_e = q0.pop_front(); m_got = 1'b1; end
                            1: if (q1.size() > 0) begin m_e = q1.pop_front(); m_got = 1'b1; end
                            default: if (q2.size() > 0) begin m_e = q2.pop_front(); m_got = 1'b1; end
                        endcase
                        if (!m_got) begin
                            n_checks++; n_err++;
                            $display("FAIL unexpected_step: axis %0d stepped at cycle %0d, expected none", i, cyc);
                        end else begin
                            check($sformatf("step_dir_ax%0d", i), 32'(dir[i]), 32'(m_e.d));
                            check($sformatf("step_pos_ax%0d", i), 32'(position[i*PB +: PB]), 32'(m_e.p));
                            if (m_e.gap != 0)
                                check($sformatf("step_gap_ax%0d", i), 32'(cyc - last_rise[i]), 32'(m_e.gap));
                        end
                        last_rise[i] = cyc;
                        rise_cnt[i]++;
                        width[i] = 1;
                    end else if (step[i]) begin
                        width[i]++;
                    end else if (prev[i]) begin
                        check($sformatf("pulse_width_ax%0d", i), 32'(width[i]), 32'(PW));
                    end
                    prev[i] = step[i];
                end
            end
        end
    end

    initial begin
        int  after[N];
        int  base[N];
        bit  sent_dup, seen2;
        rst = 1'b1; home_req = 1'b0; jog_pos = '0; jog_neg = '0; limit = '0;
        for (int i = 0; i < N; i++) model_pos[i] = 8'h00;
        cycles(3);
        check("rst_step", 32'(step), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_position", 32'(position), 0);
        check("rst_flags", {29'd0, homed, busy, fault}, 0);
        rst = 1'b0;
        cycles(2);

        // Jog axis 0 away from home for five step periods
        push_moves(0, 5, 1'b1);
        base[0] = rise_cnt[0];
        jog_pos = 3'b001;
        wait_rises(0, base[0] + 5, 120);
        jog_pos = '0;
        cycles(15);
        check("jog_pos5_position0", 32'(position[7:0]), 32'h05);
        check("jog_pos5_dir0", 32'(dir[0]), 1);

        // Reset in the middle of a pulse
        push_moves(0, 1, 1'b1);
        base[0] = rise_cnt[0];
        jog_pos = 3'b001;
        wait_rises(0, base[0] + 1, 40);
        cycles(1);
        rst = 1'b1;
        #1;
        check("midpulse_rst_step", 32'(step), 0);
        check("midpulse_rst_dir", 32'(dir), 0);
        check("midpulse_rst_position", 32'(position), 0);
        check("midpulse_rst_flags", {29'd0, homed, busy, fault}, 0);
        @(negedge clk); #1;
        rst = 1'b0; jog_pos = '0;
        model_pos[0] = 8'h00;
        cycles(2);

        // Contradictory jog and jog into an asserted endstop: no motion
        jog_pos = 3'b111; jog_neg = 3'b111;
        cycles(35);
        jog_pos = '0; jog_neg = '0;
        check("jog_both_position", 32'(position), 0);
        limit = 3'b010; jog_neg = 3'b010;
        cycles(35);
        jog_neg = '0; limit = '0;
        check("jog_neg_at_limit_pos1", 32'(position[15:8]), 0);

        // Jog toward home from 0 without endstop wraps
        push_moves(0, 1, 1'b0);
        base[0] = rise_cnt[0];
        jog_neg = 3'b001;
        wait_rises(0, base[0] + 1, 40);
        jog_neg = '0;
        cycles(12);
        check("jog_neg_wrap_pos0", 32'(position[7:0]), 32'hFF);
        check("jog_neg_wrap_dir0", 32'(dir[0]), 0);

        // Homing: endstops trip after 4, 7 and 2 steps; extra home_req mid-phase
        push_moves(0, 4, 1'b0);
        push_moves(1, 7, 1'b0);
        push_moves(2, 2, 1'b0);
        for (int i = 0; i < N; i++) model_pos[i] = 8'h00;
        after = '{4, 7, 2};
        for (int i = 0; i < N; i++) base[i] = rise_cnt[i];
        sent_dup = 1'b0; seen2 = 1'b0;
        pulse_home();
        check("home_start_busy", 32'(busy), 1);
        check("home_start_homed", 32'(homed), 0);
        for (int c = 0; c < 600 && !homed; c++) begin
            @(negedge clk); #1;
            home_req = 1'b0;
            for (int a = 0; a < N; a++)
                if (!limit[a] && rise_cnt[a] - base[a] >= after[a]) limit[a] = 1'b1;
            if (!sent_dup && rise_cnt[0] - base[0] == 2) begin
                home_req = 1'b1; sent_dup = 1'b1;
            end
            if (!seen2 && rise_cnt[2] - base[2] >= 1) begin
                seen2 = 1'b1;
                check("phaseb_pos0", 32'(position[7:0]), 0);
                check("phaseb_pos1", 32'(position[15:8]), 0);
                check("phaseb_busy", 32'(busy), 1);
                check("phaseb_first_step_delay", 32'(last_rise[2] - last_rise[1]), 32'(SD));
            end
        end
        home_req = 1'b0;
        check("home_done_homed", 32'(homed), 1);
        check("home_done_busy", 32'(busy), 0);
        check("home_done_fault", 32'(fault), 0);
        check("home_done_position", 32'(position), 0);

        // Leave endstop after homing
        push_moves(0, 1, 1'b1);
        base[0] = rise_cnt[0];
        jog_pos = 3'b001;
        wait_rises(0, base[0] + 1, 40);
        jog_pos = '0;
        cycles(12);
        check("leave_endstop_pos0", 32'(position[7:0]), 32'h01);

        // Timeout: endstops never trip
        limit = '0;
        push_moves(0, 20, 1'b0);
        push_moves(1, 20, 1'b0);
        base[0] = rise_cnt[0]; base[1] = rise_cnt[1];
        pulse_home();
        wait_rises(0, base[0] + 20, 400);
        wait_rises(1, base[1] + 20, 40);
        cycles(25);
        check("timeout_fault", 32'(fault), 1);
        check("timeout_busy", 32'(busy), 0);
        check("timeout_homed", 32'(homed), 0);
        check("timeout_pos0", 32'(position[7:0]), 32'hED);
        check("timeout_pos1", 32'(position[15:8]), 32'hEC);
        check("timeout_pos2", 32'(position[23:16]), 0);

        // Recovery with all endstops already asserted: zero steps
        limit = 3'b111;
        pulse_home();
        cycles(5);
        check("recover_fault", 32'(fault), 0);
        check("recover_homed", 32'(homed), 1);
        check("recover_busy", 32'(busy), 0);
        check("recover_position", 32'(position), 0);

        cycles(20);
        check("scoreboard_empty", 32'(q0.size() + q1.size() + q2.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_motion_controller.md
Name: axis_motion_controller

Overview:
- Parametrised N-axis stepper motion controller for the printer gantry.
- Generates step/dir pulses at a programmable rate from a shared prescaler and keeps a signed position counter per axis.
- Runs a two-phase homing sequence: axes 0..N-2 together, then axis N-1 (tool/Z); aborts on timeout.
- Supports per-axis jogging once idle. Sits between the button/switch debounce logic and the stepper driver pins.

Parameters:
- N_AXES, 3, number of axes; axis N_AXES-1 homes last. Legal range 2..8.
- STEP_DIV, 50000, clk cycles per step period; must be > PULSE_W+1.
- PULSE_W, 100, step high time in clk cycles; must be >= 1.
- POS_W, 16, position counter width, two's complement.
- HOME_DIR, '0, N_AXES-bit mask; bit i is the dir level that moves axis i toward its endstop.
- HOME_MAX_STEPS, 4000, max steps per axis per homing phase before fault.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- home_req  in  1  single-cycle pulse; starts homing
- jog_pos  in  N_AXES  per-axis jog away from home (level)
- jog_neg  in  N_AXES  per-axis jog toward home (level)
- limit  in  N_AXES  endstop, 1 = at home; already synchronised
- step  out  N_AXES  step pulses to drivers
- dir  out  N_AXES  direction to drivers
- position  out  N_AXES*POS_W  axis i in bits [i*POS_W +: POS_W]
- homed  out  1  all axes homed since last home_req
- busy  out  1  homing in progress
- fault  out  1  homing timeout, sticky

Behaviour:
- Reset (async assert, sync release):
  - step, dir, position, homed, busy, fault = 0.
  - Prescaler = 0; FSM = IDLE.
- Prescaler:
  - Free-running 0..STEP_DIV-1. tick = 1 for one cycle when count == STEP_DIV-1.
- Per-axis step engine:
  - At a tick cycle T, if the axis has a move request, dir is registered at T.
  - step is high for cycles T+1..T+PULSE_W.
  - dir is only updated on tick cycles, so it is stable for the whole pulse.
  - position updates on the step rising cycle (T+1): +1 if moving away from home (dir != HOME_DIR[i]), -1 if toward home. Wraps modulo 2^POS_W.
- FSM states: IDLE, HOME_A, HOME_B, FAULT.
- IDLE:
  - Jog is active. Axis i requests away-from-home if jog_pos[i] & !jog_neg[i].
  - Axis i requests toward-home if jog_neg[i] & !jog_pos[i] & !limit[i].
  - Both jog inputs high, or neither, means no move.
  - home_req -> HOME_A; homed cleared, busy = 1, per-axis step counters cleared.
- HOME_A:
  - Axes 0..N-2 with limit = 0 step toward home on every tick.
  - When an axis's limit = 1: that axis stops and its position is loaded with 0 in the same cycle.
  - Axis N-1 and jog inputs are ignored.
  - All axes 0..N-2 at limit -> HOME_B (next cycle).
  - Any axis reaching HOME_MAX_STEPS steps without limit -> FAULT.
- HOME_B:
  - Axis N-1 homes the same way.
  - On limit: position[N-1] = 0, homed = 1, busy = 0, next state IDLE.
  - Timeout -> FAULT.
- FAULT:
  - fault = 1, busy = 0, homed = 0; no motion, jog ignored.
  - home_req clears fault and enters HOME_A.
- home_req while busy is ignored.
- An axis already at limit when its phase starts takes 0 steps and is zeroed immediately.
- A step pulse already in flight always completes its PULSE_W width, even on FSM transition. The only exception is rst, which clears it immediately.
- Jog toward home with limit = 1 is suppressed; position is not changed.
- After homing, leaving the endstop via jog_pos is allowed; position counts up from 0.

Test Plan:
Benches use N_AXES=3, STEP_DIV=10, PULSE_W=3, POS_W=8, HOME_DIR=3'b000, HOME_MAX_STEPS=20 unless noted.
- Reset: assert rst mid-pulse -> step and dir drop to 0 within the same cycle; position = 0, homed = 0, busy = 0.
- Step timing: jog_pos = 3'b001 for 5 periods -> step[0] high exactly 3 cycles every 10 cycles; dir[0] = 1 from the tick cycle; position[0] = 5; step[1] and step[2] = 0.
- Homing order:
  - Stimulus: limit[0] set after 4 steps, limit[1] after 7; home_req.
  - Required: axis 2 does not step until cycle after limit[1] rises.
  - Required: positions 0 and 1 = 0, busy = 1; then limit[2] set after 2 steps -> homed = 1, busy = 0.
- Timeout: limit never asserted -> axes 0 and 1 each emit exactly 20 steps, then fault = 1, busy = 0. Then home_req with limits held high -> fault = 0, homed = 1 with zero steps.
- Jog edge cases:
  - jog_pos = jog_neg = 1 -> no steps.
  - jog_neg[1] with limit[1] = 1 -> no steps, position unchanged.
  - jog_neg[0] from position 0, no limit -> position 8'hFF (wrap).
- home_req during HOME_A -> ignored; sequence and step count unchanged.
